// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a registered-read FIFO; tx falls two cycles after the pop.
// One pop per frame, only while the line is idle; frames in flight always complete.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic ODD_PARITY = (PARITY == 2);
    localparam logic HAS_PARITY = (PARITY != 0);
    localparam logic LAST_STOP  = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             par_bit;
    logic             stop_idx;
    logic             bit_end;

    assign bit_end = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            stop_idx   <= 1'b0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    tx       <= 1'b1;
                    if (enable && !fifo_empty) begin
                        state      <= S_FETCH;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    // FIFO read data is valid only now, one cycle after the pop
                    shift    <= fifo_data;
                    par_bit  <= (^fifo_data) ^ ODD_PARITY;
                    baud_cnt <= '0;
                    tx       <= 1'b0;
                    state    <= S_START;
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (HAS_PARITY) begin
                                tx    <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (stop_idx == LAST_STOP) begin
                            stop_idx   <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: four transmitters at 4 clocks/bit (none, even, odd parity, two stop bits).
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en;
    logic [3:0] fempty;
    logic [3:0] rd;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [3:0] done;
    logic [7:0] fdat [4];
    logic [7:0] mem [4][16];
    logic [3:0] wp [4] = '{default: 4'd0};
    logic [3:0] rp [4] = '{default: 4'd0};
    int         cyc = 0;
    int         rd_cnt [4] = '{default: 0};
    int         rd_cyc [4] = '{default: 0};
    int         done_cnt [4] = '{default: 0};
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fifo_uart_tx #(
            .CLKS_PER_BIT(4),
            .PARITY      ((g == 1) ? 1 : (g == 2) ? 2 : 0),
            .STOP_BITS   ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .enable    (en[g]),
            .fifo_empty(fempty[g]),
            .fifo_data (fdat[g]),
            .fifo_rd_en(rd[g]),
            .tx        (tx[g]),
            .busy      (busy[g]),
            .frame_done(done[g])
        );
    end

    // FIFO model: registered read data, valid the cycle after the pop
    always_comb begin
        for (int i = 0; i < 4; i++) fempty[i] = (rp[i] == wp[i]);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (rd[i] && rp[i] != wp[i]) begin
                fdat[i] <= mem[i][rp[i]];
                rp[i]   <= rp[i] + 4'd1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rd[i] === 1'b1) begin
                rd_cnt[i]++;
                rd_cyc[i] = cyc;
            end
            if (done[i] === 1'b1) done_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [7:0] b);
        mem[ch][wp[ch]] = b;
        wp[ch] = wp[ch] + 4'd1;
    endtask

    task automatic wait_fall(input logic [1:0] ch, input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tx[ch] !== 1'b0 && k < 400);
        check({tag, "_start"}, 32'(tx[ch]), 32'd0);
    endtask

    // Samples a whole frame from the start-bit negedge, then the frame_done cycle.
    task automatic run_frame(input logic [1:0] ch, input logic [7:0] b, input int par,
                             input int stops, input int drop_at, input string tag,
                             output int fall_c, output int done_c);
        logic [11:0] expv;
        logic [11:0] obs;
        logic [3:0]  bi;
        int          nb;
        int          bad;
        int          nbusy;
        expv      = '1;
        expv[0]   = 1'b0;
        expv[8:1] = b;
        nb        = 9;
        if (par != 0) begin
            expv[9] = (^b) ^ (par == 2);
            nb      = 10;
        end
        nb    = nb + stops;
        obs   = '1;
        bad   = 0;
        nbusy = 0;
        wait_fall(ch, tag);
        fall_c = cyc;
        for (int i = 0; i < nb * 4; i++) begin
            if (i > 0) @(negedge clk);
            if (i == drop_at) en[ch] = 1'b0;
            bi = 4'(i / 4);
            if (tx[ch] !== expv[bi]) bad++;
            if (i % 4 == 2) obs[bi] = tx[ch];
            if (busy[ch] !== 1'b1) nbusy++;
        end
        @(negedge clk);
        done_c = cyc;
        check({tag, "_bits"}, 32'(obs), 32'(expv));
        check({tag, "_bad_samples"}, bad, 0);
        check({tag, "_busy_in_frame"}, nbusy, 0);
        check({tag, "_frame_done"}, 32'(done[ch]), 32'd1);
        check({tag, "_busy_end"}, 32'(busy[ch]), 32'd0);
        check({tag, "_tx_end"}, 32'(tx[ch]), 32'd1);
    endtask

    initial begin
        int f1, d1, f2, d2, viol;
        rst = 1'b1;
        en  = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'hF);
        check("rst_rd", 32'(rd), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b0;

        // Enabled but empty: nothing may happen
        en   = 4'hF;
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 4'hF || rd !== 4'h0 || busy !== 4'h0) viol++;
        end
        check("empty_idle", viol, 0);
        en = 4'h0;

        // Single byte, no parity: 0,1,0,1,0,0,1,0,1,1
        push(2'd0, 8'hA5);
        en[0] = 1'b1;
        run_frame(2'd0, 8'hA5, 0, 1, -1, "a5_none", f1, d1);
        check("a5_none_rd_to_tx", 32'(f1 - rd_cyc[0]), 32'd2);
        repeat (3) @(negedge clk);
        check("a5_none_pops", rd_cnt[0], 1);
        check("a5_none_done_pulses", done_cnt[0], 1);

        // Parity: even 0xA5 -> 0, even 0x01 -> 1, odd 0xA5 -> 1
        push(2'd1, 8'hA5);
        push(2'd1, 8'h01);
        en[1] = 1'b1;
        run_frame(2'd1, 8'hA5, 1, 1, -1, "a5_even", f1, d1);
        run_frame(2'd1, 8'h01, 1, 1, -1, "01_even", f1, d1);
        check("even_pops", rd_cnt[1], 2);
        push(2'd2, 8'hA5);
        en[2] = 1'b1;
        run_frame(2'd2, 8'hA5, 2, 1, -1, "a5_odd", f1, d1);

        // Back-to-back with two stop bits
        push(2'd3, 8'h00);
        push(2'd3, 8'hFF);
        en[3] = 1'b1;
        run_frame(2'd3, 8'h00, 0, 2, -1, "b2b_00", f1, d1);
        @(negedge clk);
        check("b2b_fetch_busy", 32'(busy[3]), 32'd1);
        check("b2b_fetch_tx", 32'(tx[3]), 32'd1);
        @(negedge clk);
        check("b2b_wait_busy", 32'(busy[3]), 32'd1);
        check("b2b_wait_tx", 32'(tx[3]), 32'd1);
        run_frame(2'd3, 8'hFF, 0, 2, -1, "b2b_ff", f2, d2);
        check("b2b_gap", 32'(f2 - d1), 32'd3);
        repeat (20) @(negedge clk);
        check("b2b_pops", rd_cnt[3], 2);

        // Enable dropped during data: frame completes, no further pop
        push(2'd0, 8'h3C);
        push(2'd0, 8'h37);
        run_frame(2'd0, 8'h3C, 0, 1, 14, "en_drop", f1, d1);
        repeat (30) @(negedge clk);
        check("en_drop_pops", rd_cnt[0], 2);
        check("en_drop_idle_tx", 32'(tx[0]), 32'd1);
        check("en_drop_idle_busy", 32'(busy[0]), 32'd0);

        // Reset during data bit 3 of 0x37 (bit value 0); byte is lost, 0x81 follows
        push(2'd0, 8'h81);
        en[0] = 1'b1;
        wait_fall(2'd0, "rst_mid");
        check("rst_mid_pops", rd_cnt[0], 3);
        repeat (17) @(negedge clk);
        check("rst_mid_bit3", 32'(tx[0]), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_tx", 32'(tx), 32'hF);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_rd_done", 32'({rd, done}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_frame(2'd0, 8'h81, 0, 1, -1, "after_rst", f1, d1);
        check("after_rst_rd_to_tx", 32'(f1 - rd_cyc[0]), 32'd2);
        check("after_rst_pops", rd_cnt[0], 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that sits directly downstream of the team's 8-bit, 16-entry FIFO. It pops one byte at a time through the FIFO's read port and serialises it as an asynchronous UART frame on `tx`: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It paces itself with an internal baud counter and never pops the FIFO while a frame is in flight.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 2..65535.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `enable` input 1: allows a new frame to start; frames already in progress always complete.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_data` input 8: FIFO read data; registered in the FIFO, valid on the cycle after `fifo_rd_en`.
- `fifo_rd_en` output 1: one-cycle pop request to the FIFO.
- `tx` output 1: serial line; idles high.
- `busy` output 1: high from FETCH through the final stop bit.
- `frame_done` output 1: one-cycle pulse after the last stop bit.

## Operation
State machine (7 states):
- **IDLE**
  - `tx`=1.
  - Goes to FETCH when `enable`=1 and `fifo_empty`=0.
- **FETCH**
  - Exactly one cycle with `fifo_rd_en`=1; always goes to WAIT.
- **WAIT**
  - One cycle. `fifo_data` is captured into the shift register on the edge that ends WAIT.
  - Parity is computed from the captured byte.
  - Baud counter is cleared; `tx`<=0; goes to START.
- **START**
  - Holds `tx`=0 for `CLKS_PER_BIT` cycles, then goes to DATA with `tx`<=bit0.
- **DATA**
  - Each bit is held `CLKS_PER_BIT` cycles; bits are sent LSB first, using a 3-bit bit index.
  - After bit7 goes to PARITY if `PARITY`!=0, else STOP.
- **PARITY**
  - Bit value: even mode sends XOR of data bits; odd mode sends its inverse.
  - Held `CLKS_PER_BIT` cycles.
- **STOP**
  - `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles.
  - Then `frame_done`=1 for one cycle and the state goes to IDLE.

Rules:
- `tx`, `fifo_rd_en`, `busy` and `frame_done` are driven from registers or direct state decode; no combinational path from `fifo_empty` to `fifo_rd_en`.
- `fifo_rd_en` is asserted only in FETCH, so the block never pops an empty FIFO and issues exactly one pop per frame.
- `enable` is sampled only in IDLE. Deasserting it mid-frame has no effect until the frame ends.
- Baud counter width is ceil(log2(`CLKS_PER_BIT`)). It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary; it is never left free-running outside a frame.
- `fifo_data` is ignored outside WAIT.

## Timing
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0, state=IDLE, counters=0.
- Reset asserted mid-frame:
  - `tx` returns to 1 immediately (asynchronously).
  - The popped byte is discarded and not re-fetched.
  - After release, the block restarts in IDLE.
- Latency:
  - IDLE sees `fifo_empty`=0 at edge E0; FETCH occupies cycle E0→E1 and WAIT occupies E1→E2.
  - `tx` falls at E2.
- Frame length on the line: (1+8+P+`STOP_BITS`)×`CLKS_PER_BIT` cycles, where P=1 if parity is enabled, else 0.
- `frame_done` is high in the first cycle after the last stop-bit cycle; the state is IDLE in that same cycle.
- Back-to-back frames (FIFO non-empty): line-idle gap between the end of the stop bit and the next start bit is 3 cycles (`frame_done`/IDLE, FETCH, WAIT).
- `busy` rises at E0 (entry to FETCH) and falls together with `frame_done`.

## Test plan
- **Single byte, no parity:** `CLKS_PER_BIT`=4, `PARITY`=0, FIFO holds 0xA5.
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
  - One `fifo_rd_en` pulse; `tx` falls 2 cycles after `fifo_rd_en`; `frame_done` pulses once.
- **Parity:** byte 0xA5.
  - Even parity: parity bit = 0.
  - Odd parity: parity bit = 1.
  - Byte 0x01 with even parity: parity bit = 1.
  - Frame length is 44 cycles at `CLKS_PER_BIT`=4.
- **Back-to-back frames:** FIFO holds 0x00 then 0xFF, `STOP_BITS`=2.
  - Exactly two `fifo_rd_en` pulses.
  - Each stop period is 8 cycles high, followed by a 3-cycle idle gap.
  - Second frame data bits all 1.
  - `busy` low only during the single gap cycle.
- **Empty FIFO:** `fifo_empty`=1 for 100 cycles.
  - `fifo_rd_en` never asserted; `tx`=1; `busy`=0.
- **Enable and reset:**
  - `enable` dropped during DATA: the frame completes and no further pop occurs.
  - `rst` pulsed during bit 3: `tx`=1 within the same cycle and all outputs at reset values.
  - After release with FIFO non-empty, the next frame starts 2 cycles after FETCH.
